regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_clr_seq.sv | 50 +++++
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package regfile_pkg;
    localparam int ADDRW_DEF = 5;
    localparam int DATAW_DEF = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;
endpackage

// File: rtl/regfile_clr_seq.sv
// Power-up clear sequencer: walks x1..xN-1 writing zero, then flags ready.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDRW = ADDRW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ready,
    output logic             clr_we,
    output logic [ADDRW-1:0] clr_addr,
    output state_e           state
);
    state_e           state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == '1) state_d = RUN;
                else             cnt_d   = cnt_q + ADDRW'(1);
            end
            RUN:     ;
            default: state_d = CLEAR;
        endcase
        // Registered so ready is high exactly from the first RUN cycle.
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= ADDRW'(1);
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign state = state_q;
endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hardwired to zero, writeback bypass and a per-register
// pending (scoreboard) bit set on issue and cleared on writeback.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDRW = ADDRW_DEF,
    parameter int DATAW = DATAW_DEF,
    parameter int NRD   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 wr_en,
    input  logic [ADDRW-1:0]     addr_d,
    input  logic [DATAW-1:0]     data_d,
    input  logic                 iss_en,
    input  logic [ADDRW-1:0]     iss_addr,
    input  logic [NRD*ADDRW-1:0] rd_addr,
    output logic [NRD*DATAW-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy
);
    localparam int NREG = 1 << ADDRW;

    logic             clr_we;
    logic [ADDRW-1:0] clr_addr;
    state_e           seq_state;
    logic             run;

    logic [DATAW-1:0] regs_q [NREG];
    logic             we;
    logic [ADDRW-1:0] waddr;
    logic [DATAW-1:0] wdata;

    logic [NREG-1:0]  pending_q, pending_d;

    regfile_clr_seq #(.ADDRW(ADDRW)) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .state    (seq_state)
    );

    // No handshake back-pressure: traffic is only honoured while run is high;
    // before that, writes and issues are dropped and reads/busy return zero.
    assign run = (seq_state == RUN);

    always_comb begin
        we    = 1'b0;
        waddr = addr_d;
        wdata = data_d;
        if (clr_we) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end else if (run && wr_en && (addr_d != '0)) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) regs_q[waddr] <= wdata;
    end

    // Issue is applied after writeback so a same-cycle set wins over the clear.
    always_comb begin
        pending_d = pending_q;
        if (run) begin
            if (wr_en) pending_d[addr_d] = 1'b0;
            if (iss_en && (iss_addr != '0)) pending_d[iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin : g_rd
            logic [ADDRW-1:0] ra;
            logic             byp;
            ra  = rd_addr[i*ADDRW +: ADDRW];
            byp = wr_en && (addr_d == ra);
            if (run && (ra != '0)) begin
                rd_data[i*DATAW +: DATAW] = byp ? data_d : regs_q[ra];
                rd_busy[i]                = pending_q[ra] && !byp;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against an array model.
module tb_regfile_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready;
  logic wr_en = 1'b0;
  logic [AW-1:0] addr_d = '0;
  logic [DW-1:0] data_d = '0;
  logic iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [DW-1:0] m_regs [NREG];
  bit m_pend [NREG];
  bit m_ready;
  int m_clr;

  regfile_sb #(.ADDRW(AW), .DATAW(DW), .NRD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .wr_en(wr_en), .addr_d(addr_d), .data_d(data_d),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (wr_en && addr_d == a) return data_d;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return 1'b0;
    if (wr_en && addr_d == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic idle();
    wr_en = 1'b0;
    iss_en = 1'b0;
    addr_d = '0;
    data_d = '0;
    iss_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (!m_ready) begin
        m_clr++;
        if (m_clr == NREG - 1) begin
          m_ready = 1'b1;
          for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        end
      end else begin
        if (wr_en && addr_d != 0) m_regs[addr_d] = data_d;
        if (wr_en) m_pend[addr_d] = 1'b0;
        if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_clr = 0;
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready actual=%b required=0", ready); end
    n = 0;
    while (n < 64 && !m_ready) begin
      wr_en = 1'($urandom_range(0, 1));
      addr_d = AW'($urandom_range(0, NREG - 1));
      data_d = $urandom;
      iss_en = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, NREG - 1));
      rd_addr = {AW'($urandom_range(1, NREG - 1)), AW'($urandom_range(1, NREG - 1))};
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        errors++;
        $display("FAIL clear_reads_zero actual data=%h busy=%b required 0", rd_data, rd_busy);
      end
      tick();
      n++;
      checks++;
      if (ready !== m_ready) begin
        errors++;
        $display("FAIL clear_ready cycle=%0d actual=%b required=%b", n, ready, m_ready);
      end
    end
    checks++;
    if (n != 31) begin errors++; $display("FAIL clear_length actual=%0d required=31", n); end
    idle();
    for (int a = 0; a < NREG; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rd_data[p*DW +: DW] !== '0 || rd_busy[p] !== 1'b0) begin
          errors++;
          $display("FAIL post_clear_read x%0d actual data=%h busy=%b required 0", a + p,
                   rd_data[p*DW +: DW], rd_busy[p]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1;
    addr_d = 5'd5;
    data_d = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass actual=%h required=deadbeef", rd_data[DW-1:0]);
    end
    checks++;
    if (rd_data[2*DW-1:DW] !== '0) begin
      errors++; $display("FAIL bypass_x0_port actual=%h required=0", rd_data[2*DW-1:DW]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL stored_read actual=%h required=deadbeef", rd_data[DW-1:0]);
    end
  endtask

  task automatic test_busy();
    logic [DW-1:0] v;
    v = $urandom;
    iss_en = 1'b1;
    iss_addr = 5'd7;
    rd_addr = {5'd7, 5'd0};
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL busy_before_issue actual=%b required=0", rd_busy[1]); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL busy_after_issue actual=%b required=1", rd_busy[1]); end
    wr_en = 1'b1;
    addr_d = 5'd7;
    data_d = v;
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0 || rd_data[2*DW-1:DW] !== v) begin
      errors++;
      $display("FAIL busy_writeback_cycle actual busy=%b data=%h required busy=0 data=%h", rd_busy[1], rd_data[2*DW-1:DW], v);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0 || rd_data[2*DW-1:DW] !== v) begin
      errors++;
      $display("FAIL busy_after_writeback actual busy=%b data=%h required busy=0 data=%h", rd_busy[1], rd_data[2*DW-1:DW], v);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] v;
    v = $urandom;
    iss_en = 1'b1;
    iss_addr = 5'd9;
    wr_en = 1'b1;
    addr_d = 5'd9;
    data_d = v;
    tick();
    idle();
    rd_addr = {5'd9, 5'd9};
    #1;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd_busy[p] !== 1'b1 || rd_data[p*DW +: DW] !== v) begin
        errors++;
        $display("FAIL set_wins port%0d actual busy=%b data=%h required busy=1 data=%h", p, rd_busy[p], rd_data[p*DW +: DW], v);
      end
    end
    wr_en = 1'b1;
    addr_d = 5'd9;
    data_d = ~v;
    tick();
    idle();
  endtask

  task automatic test_x0();
    wr_en = 1'b1;
    addr_d = 5'd0;
    data_d = 32'h1234;
    iss_en = 1'b1;
    iss_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      errors++; $display("FAIL x0_same_cycle actual data=%h busy=%b required 0", rd_data, rd_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      errors++; $display("FAIL x0_after actual data=%h busy=%b required 0", rd_data, rd_busy);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] hi;
      hi = (k % 2 == 0) ? AW'(7) : AW'(NREG - 1);
      wr_en = ($urandom_range(0, 99) < 50);
      addr_d = AW'($urandom_range(0, int'(hi)));
      data_d = $urandom;
      iss_en = ($urandom_range(0, 99) < 40);
      iss_addr = AW'($urandom_range(0, int'(hi)));
      rd_addr = {AW'($urandom_range(0, int'(hi))), AW'($urandom_range(0, int'(hi)))};
      if ($urandom_range(0, 9) == 0) rd_addr[2*AW-1:AW] = rd_addr[AW-1:0];
      #1;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rd_data[p*DW +: DW] !== exp_data(rd_addr[p*AW +: AW]) ||
            rd_busy[p] !== exp_busy(rd_addr[p*AW +: AW])) begin
          errors++;
          $display("FAIL random it=%0d port%0d x%0d actual data=%h busy=%b required data=%h busy=%b",
                   k, p, rd_addr[p*AW +: AW], rd_data[p*DW +: DW], rd_busy[p],
                   exp_data(rd_addr[p*AW +: AW]), exp_busy(rd_addr[p*AW +: AW]));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    wr_en = 1'b1;
    addr_d = 5'd3;
    data_d = 32'hA5A5_0003;
    iss_en = 1'b1;
    iss_addr = 5'd3;
    tick();
    idle();
    rd_addr = {5'd3, 5'd3};
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy actual=%b required=1", rd_busy[0]); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ready !== 1'b0 || rd_busy !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL async_reset actual ready=%b busy=%b data=%h required all 0", ready, rd_busy, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      tick();
      checks++;
      if (ready !== m_ready) begin
        errors++; $display("FAIL reclear_ready cycle=%0d actual=%b required=%b", n, ready, m_ready);
      end
    end
    #1;
    checks++;
    if (rd_data[DW-1:0] !== '0 || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL x3_after_reclear actual data=%h busy=%b required data=0 busy=0", rd_data[DW-1:0], rd_busy[0]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_busy();
    test_same_cycle();
    test_x0();
    test_random();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
